operand_fetch: RTL and testbench
================================

# operand_fetch

Issue/writeback stage wrapped around the 8-bit ALU. Accepts 16-bit instructions over a valid/ready handshake, reads two operands from an 8-entry register file, and drives the ALU's `a`, `b` and `ctrl` from a pipeline register. It writes the ALU's combinational `result` back into the register file one cycle later. Back-to-back dependencies are resolved by forwarding, so no bubbles are inserted.

## Interface
- `DATA_W`, default 8: operand width; must equal the ALU width.
- `R0_ZERO`, default 1: when 1, register 0 always reads 0 and ignores writes.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `instr` is valid.
- `in_ready` out 1: stage can accept; equals `~hold`.
- `instr` in 16: instruction word.
- `hold` in 1: freezes the EX register and suppresses writeback.
- `alu_a` out DATA_W: ALU operand a (registered).
- `alu_b` out DATA_W: ALU operand b (registered).
- `alu_ctrl` out 3: ALU opcode (registered).
- `ex_valid` out 1: EX register holds a live instruction.
- `ex_rd` out 3: destination register of the EX instruction.
- `alu_result` in DATA_W: ALU combinational result for the current EX contents.
- `dbg_addr` in 3: debug read address.
- `dbg_data` out DATA_W: combinational register-file read; shows architectural state only, no forwarding.

## Operation
Instruction format:
- `op=instr[15:13]`, `rd=instr[12:10]`, `rs1=instr[9:7]`, `rs2=instr[6:4]`, `imm=instr[7:0]`.

Decode:
- **op 000–101 (R-type):** a = R[rs1], b = R[rs2], ctrl = op (ADD, SUB, AND, OR, XOR, NOR).
- **op 110 (LDI):** a = imm, b = 0, ctrl = 000; rd receives imm through the ALU add path.
- **op 111 (NOP):** accepted, but the EX register is loaded with `ex_valid=0`; no writeback.

Operand read with forwarding:
- If `ex_valid` is set, `ex_rd` equals the source register, and (`R0_ZERO=0` or the source is not 0), the source value is `alu_result`.
- Otherwise the source value comes from the register file.
- With `R0_ZERO=1`, R0 always reads 0.

Stage behaviour:
- **Accept:** `in_valid & in_ready` at an edge loads `alu_a`, `alu_b`, `alu_ctrl` and `ex_rd` from the decode. `ex_valid` is set to (op≠111).
- **Bubble:** `~in_valid & ~hold` at an edge clears `ex_valid`. `alu_a`, `alu_b`, `alu_ctrl` and `ex_rd` keep their values.
- **Writeback:** at each edge where `ex_valid & ~hold`, R[`ex_rd`] ← `alu_result`. The write is ignored for rd=0 when `R0_ZERO=1`.
- **Hold:** while `hold` is high, all EX outputs are frozen, there is no writeback, `in_ready=0`, and `instr` is not consumed.
- **Simultaneous writeback and decode read of the same register:** the forwarded value is used. The result is identical to the value being written.

Reset:
- All registers R0–R7 = 0.
- `ex_valid=0`, `alu_a=0`, `alu_b=0`, `alu_ctrl=000`, `ex_rd=0`.
- `in_ready` = `~hold`, so it reads 1 during reset when `hold=0`.
- `rst` overrides `hold` and every other input.
- Asserting reset with an instruction in EX discards it: no writeback occurs at the reset edge.

Arithmetic:
- Results are truncated to DATA_W bits; there is no carry or flag state.

## Timing
- The instruction accepted at edge T is visible on `alu_*`/`ex_valid` after T. Its result is written at edge T+1 (if `hold=0`) and appears on `dbg_data` after T+1.
- Throughput is one instruction per cycle while `hold=0`. A dependent instruction issued the cycle after its producer sees the correct operand with zero stall.
- `hold` high for N cycles delays both the writeback and the next acceptance by exactly N cycles. The EX instruction is written back once, at the first edge with `hold=0`.
- `in_ready` is combinational from `hold` only, with no dependence on `in_valid`.
- `dbg_data` is combinational from `dbg_addr` and the register file.

## Test plan
1. **Reset:** `rst` for 2 cycles, then sweep `dbg_addr` 0–7 → all read 0x00; `ex_valid=0`, `alu_a=alu_b=0`, `alu_ctrl=000`.
2. **Immediates:** LDI R1,0x7F; LDI R2,0x81; ADD R3,R1,R2 issued back-to-back → for the ADD, `alu_a=0x7F` and `alu_b=0x81` (forwarded). R3=0x00 after writeback (wrap-around).
3. **All ALU ops:** with R1=0xF0 and R2=0x3C, issue SUB, AND, OR, XOR, NOR into R4–R7 and R3 → registers hold 0xB4, 0x30, 0xFC, 0xCC, 0x03.
4. **Hold:** `hold=1` for 3 cycles with ADD R3,R1,R2 in EX → `in_ready=0`, outputs stable, R3 unchanged. On release, R3 is written exactly once and the pending `instr` is accepted on the release edge.
5. **R0 and NOP:** LDI R0,0x55, then ADD R1,R0,R0 → R0 reads 0x00 and R1=0x00 (no forwarding from R0). NOP in EX → `ex_valid=0`, no register changes.
6. **Reset mid-operation:** `rst` asserted on the edge after accepting LDI R5,0xAA → R5 stays 0x00 and `ex_valid=0`.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch: issue/writeback stage in front of an 8-bit ALU.
// Decodes 16-bit instructions, reads two operands from an 8-entry register
// file (with forwarding from the EX register) and latches them into the
// ALU-facing pipeline register. The ALU's combinational result is written
// back into the register file on the following edge.
module operand_fetch #(
    parameter int DATA_W  = 8,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    input  logic              hold,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_ctrl,
    output logic              ex_valid,
    output logic [2:0]        ex_rd,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    logic [DATA_W-1:0] regs_r [0:7];
    logic [DATA_W-1:0] alu_a_r;
    logic [DATA_W-1:0] alu_b_r;
    logic [2:0]        alu_ctrl_r;
    logic              ex_valid_r;
    logic [2:0]        ex_rd_r;

    logic [2:0]        op_s;
    logic [2:0]        rd_s;
    logic [2:0]        rs1_s;
    logic [2:0]        rs2_s;
    logic [7:0]        imm_s;
    logic [DATA_W-1:0] src1_s;
    logic [DATA_W-1:0] src2_s;
    logic [DATA_W-1:0] dec_a_s;
    logic [DATA_W-1:0] dec_b_s;
    logic [2:0]        dec_ctrl_s;
    logic              wr_en_s;

    assign op_s  = instr[15:13];
    assign rd_s  = instr[12:10];
    assign rs1_s = instr[9:7];
    assign rs2_s = instr[6:4];
    assign imm_s = instr[7:0];

    // Stage can accept whenever it is not frozen; independent of in_valid.
    assign in_ready = ~hold;

    // Writeback is only for a live EX instruction, never while frozen, never into a hardwired R0.
    assign wr_en_s = ex_valid_r & ~hold & ~(R0_ZERO && (ex_rd_r == 3'd0));

    assign alu_a    = alu_a_r;
    assign alu_b    = alu_b_r;
    assign alu_ctrl = alu_ctrl_r;
    assign ex_valid = ex_valid_r;
    assign ex_rd    = ex_rd_r;

    // Source operand read: forward the in-flight EX result, else the register file.
    always_comb begin
        src1_s = {DATA_W{1'b0}};
        src2_s = {DATA_W{1'b0}};
        if (R0_ZERO && (rs1_s == 3'd0)) begin
            src1_s = {DATA_W{1'b0}};
        end else if (ex_valid_r && (ex_rd_r == rs1_s)) begin
            src1_s = alu_result;
        end else begin
            src1_s = regs_r[rs1_s];
        end
        if (R0_ZERO && (rs2_s == 3'd0)) begin
            src2_s = {DATA_W{1'b0}};
        end else if (ex_valid_r && (ex_rd_r == rs2_s)) begin
            src2_s = alu_result;
        end else begin
            src2_s = regs_r[rs2_s];
        end
    end

    // Instruction decode into ALU operands and opcode.
    always_comb begin
        dec_a_s    = src1_s;
        dec_b_s    = src2_s;
        dec_ctrl_s = op_s;
        case (op_s)
            OP_LDI: begin
                dec_a_s    = DATA_W'(imm_s);
                dec_b_s    = {DATA_W{1'b0}};
                dec_ctrl_s = 3'b000;
            end
            default: begin
                dec_a_s    = src1_s;
                dec_b_s    = src2_s;
                dec_ctrl_s = op_s;
            end
        endcase
    end

    // EX pipeline register: load on accept, drop validity on bubble, freeze on hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_r    <= {DATA_W{1'b0}};
            alu_b_r    <= {DATA_W{1'b0}};
            alu_ctrl_r <= 3'b000;
            ex_rd_r    <= 3'd0;
            ex_valid_r <= 1'b0;
        end else if (!hold) begin
            if (in_valid) begin
                alu_a_r    <= dec_a_s;
                alu_b_r    <= dec_b_s;
                alu_ctrl_r <= dec_ctrl_s;
                ex_rd_r    <= rd_s;
                ex_valid_r <= (op_s != OP_NOP);
            end else begin
                ex_valid_r <= 1'b0;
            end
        end else begin
            ex_valid_r <= ex_valid_r;
        end
    end

    // Register file writeback of the ALU result; reset discards any in-flight write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[ex_rd_r] <= alu_result;
        end else begin
            regs_r[ex_rd_r] <= regs_r[ex_rd_r];
        end
    end

    // Debug port shows architectural register state only.
    always_comb begin
        if (R0_ZERO && (dbg_addr == 3'd0)) begin
            dbg_data = {DATA_W{1'b0}};
        end else begin
            dbg_data = regs_r[dbg_addr];
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, hand sequences for hold,
// R0/NOP and reset corner cases, then randomized traffic against an
// instruction-level model of the register file.
`timescale 1ns/1ps
module tb_operand_fetch;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic        hold;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_ctrl;
    logic        ex_valid;
    logic [2:0]  ex_rd;
    logic [7:0]  alu_result;
    logic [2:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int tests = 0;
    int fails = 0;

    operand_fetch #(.DATA_W(8), .R0_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .hold(hold), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ctrl(alu_ctrl), .ex_valid(ex_valid), .ex_rd(ex_rd),
        .alu_result(alu_result), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // External ALU
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c);
        case (c)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction
    assign alu_result = alu_f(alu_a, alu_b, alu_ctrl);

    function automatic logic [15:0] rtype(input logic [2:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 4'h0};
    endfunction
    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
        return {3'b110, rd, 2'b00, imm};
    endfunction

    // Instruction-level reference: sequential execution of accepted instructions
    logic [7:0] ref_regs [0:7];
    logic [7:0] ea, eb;
    logic [2:0] ec, erd;
    logic       ev, known;

    function automatic logic [7:0] rref(input logic [2:0] r);
        return (r == 3'd0) ? 8'h00 : ref_regs[r];
    endfunction

    task automatic ref_exec(input logic [15:0] ins);
        logic [2:0] op;
        op = ins[15:13];
        if (op == 3'b111) begin
            ev = 1'b0;
            known = 1'b0;
        end else begin
            if (op == 3'b110) begin
                ea = ins[7:0]; eb = 8'h00; ec = 3'd0;
            end else begin
                ea = rref(ins[9:7]); eb = rref(ins[6:4]); ec = op;
            end
            erd = ins[12:10];
            ev = 1'b1;
            known = 1'b1;
            if (erd != 3'd0) ref_regs[erd] = alu_f(ea, eb, ec);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 8; i++) ref_regs[i] = 8'h00;
        ea = 8'h00; eb = 8'h00; ec = 3'd0; erd = 3'd0; ev = 1'b0; known = 1'b1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            chk($sformatf("%s_r%0d", tag, r), {8'h00, dbg_data}, {8'h00, ref_regs[r]});
        end
    endtask

    task automatic check_ex(input string tag);
        chk({tag, "_ex_valid"}, {15'h0, ex_valid}, {15'h0, ev});
        if (ev || known) begin
            chk({tag, "_alu_a"}, {8'h00, alu_a}, {8'h00, ea});
            chk({tag, "_alu_b"}, {8'h00, alu_b}, {8'h00, eb});
            chk({tag, "_alu_ctrl"}, {13'h0, alu_ctrl}, {13'h0, ec});
        end
        if (ev) chk({tag, "_ex_rd"}, {13'h0, ex_rd}, {13'h0, erd});
    endtask

    typedef struct {
        logic [15:0] ins;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  ctrl;
    } vec_t;
    vec_t tbl [10];
    logic [7:0] exp_regs [0:7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rins;
        logic        h, v;

        tbl[0] = '{ldi(3'd1, 8'h7F), 8'h7F, 8'h00, 3'd0};
        tbl[1] = '{ldi(3'd2, 8'h81), 8'h81, 8'h00, 3'd0};
        tbl[2] = '{rtype(3'd0, 3'd3, 3'd1, 3'd2), 8'h7F, 8'h81, 3'd0};
        tbl[3] = '{ldi(3'd1, 8'hF0), 8'hF0, 8'h00, 3'd0};
        tbl[4] = '{ldi(3'd2, 8'h3C), 8'h3C, 8'h00, 3'd0};
        tbl[5] = '{rtype(3'd1, 3'd4, 3'd1, 3'd2), 8'hF0, 8'h3C, 3'd1};
        tbl[6] = '{rtype(3'd2, 3'd5, 3'd1, 3'd2), 8'hF0, 8'h3C, 3'd2};
        tbl[7] = '{rtype(3'd3, 3'd6, 3'd1, 3'd2), 8'hF0, 8'h3C, 3'd3};
        tbl[8] = '{rtype(3'd4, 3'd7, 3'd1, 3'd2), 8'hF0, 8'h3C, 3'd4};
        tbl[9] = '{rtype(3'd5, 3'd3, 3'd1, 3'd2), 8'hF0, 8'h3C, 3'd5};
        exp_regs[0] = 8'h00; exp_regs[1] = 8'hF0; exp_regs[2] = 8'h3C; exp_regs[3] = 8'h03;
        exp_regs[4] = 8'hB4; exp_regs[5] = 8'h30; exp_regs[6] = 8'hFC; exp_regs[7] = 8'hCC;

        // Reset
        rst = 1'b1; in_valid = 1'b0; hold = 1'b0; instr = 16'h0; dbg_addr = 3'd0;
        ref_reset();
        step();
        chk("rst_in_ready", {15'h0, in_ready}, 16'h0001);
        step();
        rst = 1'b0;
        #1;
        check_regs("reset");
        check_ex("reset");

        // Immediates with forwarding, then every ALU op
        for (int i = 0; i < 10; i++) begin
            instr = tbl[i].ins; in_valid = 1'b1;
            step();
            chk($sformatf("tbl%0d_a", i), {8'h00, alu_a}, {8'h00, tbl[i].a});
            chk($sformatf("tbl%0d_b", i), {8'h00, alu_b}, {8'h00, tbl[i].b});
            chk($sformatf("tbl%0d_ctrl", i), {13'h0, alu_ctrl}, {13'h0, tbl[i].ctrl});
            chk($sformatf("tbl%0d_v", i), {15'h0, ex_valid}, 16'h0001);
            if (i == 3) begin
                dbg_addr = 3'd3; #1;
                chk("ldi_wrap_r3", {8'h00, dbg_data}, 16'h0000);
            end
            ref_exec(tbl[i].ins);
        end
        in_valid = 1'b0;
        step();
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r); #1;
            chk($sformatf("aluops_r%0d", r), {8'h00, dbg_data}, {8'h00, exp_regs[r]});
        end

        // Hold for 3 cycles with ADD R3,R1,R2 in EX and LDI R4 pending
        instr = rtype(3'd0, 3'd3, 3'd1, 3'd2); in_valid = 1'b1;
        step();
        ref_exec(instr);
        instr = ldi(3'd4, 8'h11); hold = 1'b1; dbg_addr = 3'd3;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_in_ready", {15'h0, in_ready}, 16'h0000);
            step();
            check_ex("hold");
            chk("hold_r3_unchanged", {8'h00, dbg_data}, 16'h0003);
        end
        hold = 1'b0;
        #1;
        chk("release_in_ready", {15'h0, in_ready}, 16'h0001);
        step();
        ref_exec(instr);
        check_ex("release");
        chk("release_r3", {8'h00, dbg_data}, 16'h002C);
        in_valid = 1'b0;
        step();
        check_regs("after_hold");

        // R0 hardwired to zero, NOP
        instr = ldi(3'd0, 8'h55); in_valid = 1'b1;
        step(); ref_exec(instr); check_ex("ldi_r0");
        instr = rtype(3'd0, 3'd1, 3'd0, 3'd0);
        step(); ref_exec(instr); check_ex("add_r0");
        instr = {3'b111, 13'h1ABC};
        step(); ref_exec(instr); check_ex("nop");
        in_valid = 1'b0;
        step();
        check_regs("r0_nop");

        // Reset right after accepting LDI R5,0xAA
        instr = ldi(3'd5, 8'hAA); in_valid = 1'b1;
        step();
        chk("pre_rst_v", {15'h0, ex_valid}, 16'h0001);
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0;
        ref_reset();
        check_ex("mid_rst");
        check_regs("mid_rst");

        // Randomized traffic with bubbles and holds
        for (int n = 0; n < 400; n++) begin
            h = ($urandom_range(0, 5) == 0);
            v = ($urandom_range(0, 3) != 0);
            rins = 16'($urandom);
            hold = h; in_valid = v; instr = rins;
            #1;
            chk("rnd_in_ready", {15'h0, in_ready}, {15'h0, ~h});
            step();
            if (!h) begin
                if (v) ref_exec(rins);
                else ev = 1'b0;
            end
            check_ex("rnd");
            if (!ev) begin
                dbg_addr = 3'($urandom_range(0, 7));
                #1;
                chk("rnd_dbg", {8'h00, dbg_data}, {8'h00, ref_regs[dbg_addr]});
            end
        end
        hold = 1'b0; in_valid = 1'b0;
        step();
        check_regs("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
